// File: rtl/dmem_pkg.sv
// Shared types and helpers for the handshaked data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // Latency counter width; covers LATENCY up to 15.
  localparam int LAT_W = 4;

  typedef struct packed {
    logic        err;
    logic [29:0] widx;
  } dmem_chk_t;

  // Word index relative to base, plus misalign/out-of-range flag.
  // span is the window size in bytes; 33 bits so a 4 GiB window does not wrap.
  function automatic dmem_chk_t dmem_check(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [32:0] span);
    logic [31:0] off;
    dmem_chk_t   r;
    off    = addr - base;
    r.widx = off[31:2];
    r.err  = (addr[1:0] != 2'b00) || ({1'b0, off} >= span);
    return r;
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Single-port word storage with per-byte write enables and a registered read.
// Contents are never reset; only the read register is.
module dmem_byte_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_idx,
  input  logic [3:0]    i_be,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // Byte-lane write; lanes with a clear enable keep their old contents.
  always_ff @(posedge clk) begin
    if (i_en && i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // Registered read; holds its value until the next read access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              r_rdata <= '0;
    else if (i_en && !i_we) r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_wait_responder.sv
// Fixed-latency, handshaked data-memory responder: one request in flight,
// response after LATENCY cycles, held until the core takes it.
// Optional DMEM_PERF_CNT_EN adds load/store/error response counters.
module dmem_wait_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_errs
`endif
);

  localparam int             AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0]    SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [LAT_W-1:0] CNT_INIT = LAT_W'(LATENCY - 1);

  dmem_state_e      r_state;
  logic [LAT_W-1:0] r_cnt;
  logic             r_req_ready, r_rsp_valid, r_err, r_load_ok;
  logic             r_we;
  logic [31:0]      r_addr, r_wdata;
  logic [3:0]       r_be;

  dmem_chk_t        w_chk;
  logic             w_last, w_mem_en, w_rsp_hs;
  logic [31:0]      w_rd;

  // Range/alignment is judged on the captured request, not the live bus.
  assign w_chk    = dmem_check(r_addr, BASE_ADDR, SPAN);
  assign w_last   = (r_state == WAIT) && (r_cnt == '0);
  // Memory touched only on the WAIT->RESP edge, and never for a bad access.
  assign w_mem_en = w_last && !w_chk.err;
  assign w_rsp_hs = r_rsp_valid && rsp_ready;

  generate
    if (AW < 30) begin : g_unused
      logic w_unused;
      assign w_unused = &{1'b0, w_chk.widx[29:AW]};
    end
  endgenerate

  dmem_byte_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_mem_en),
    .i_we    (r_we),
    .i_idx   (w_chk.widx[AW-1:0]),
    .i_be    (r_be),
    .i_wdata (r_wdata),
    .o_rdata (w_rd)
  );

  // Request/response FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      r_load_ok   <= 1'b0;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
    end else begin
      case (r_state)
        IDLE: if (req_valid && r_req_ready) begin
          r_we        <= req_we;
          r_addr      <= req_addr;
          r_be        <= req_be;
          r_wdata     <= req_wdata;
          r_cnt       <= CNT_INIT;
          r_req_ready <= 1'b0;
          r_state     <= WAIT;
        end
        WAIT: if (r_cnt == '0) begin
          r_err       <= w_chk.err;
          r_load_ok   <= !w_chk.err && !r_we;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
        RESP: if (w_rsp_hs) begin
          r_rsp_valid <= 1'b0;
          r_err       <= 1'b0;
          r_load_ok   <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_err;
  assign rsp_rdata = r_load_ok ? w_rd : 32'h0;

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] r_perf_loads, r_perf_stores, r_perf_errs;

  // Count each response once, at its handshake; errors count only as errors.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_loads  <= '0;
      r_perf_stores <= '0;
      r_perf_errs   <= '0;
    end else if (w_rsp_hs) begin
      if (r_err)     r_perf_errs   <= r_perf_errs + 1'b1;
      else if (r_we) r_perf_stores <= r_perf_stores + 1'b1;
      else           r_perf_loads  <= r_perf_loads + 1'b1;
    end
  end

  assign perf_loads  = r_perf_loads;
  assign perf_stores = r_perf_stores;
  assign perf_errs   = r_perf_errs;
`endif

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Randomized bench for dmem_wait_responder against a byte-level memory model.
module tb_dmem_wait_responder;

  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
`ifdef DMEM_PERF_CNT_EN
  logic [31:0] perf_loads, perf_stores, perf_errs;
`endif

  always #5 clk = ~clk;

  dmem_wait_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
`ifdef DMEM_PERF_CNT_EN
    ,
    .perf_loads  (perf_loads),
    .perf_stores (perf_stores),
    .perf_errs   (perf_errs)
`endif
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] m [DEPTH];
  int          p_ld = 0, p_st = 0, p_er = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction: issue, check latency, check response against the
  // model, hold under backpressure for 'hold' cycles, then retire it.
  task automatic xact(input bit we, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] wd, input int hold, output logic [31:0] rd);
    logic [31:0] off, exp_rd;
    bit          exp_err;
    int          n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = a; req_be = be; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom);
    req_addr = $urandom; req_be = 4'($urandom); req_wdata = $urandom;
    chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
    for (int k = 0; k < LAT; k++) begin
      chk("early_valid", {31'b0, rsp_valid}, 32'd0);
      rsp_ready = 1'($urandom);
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);

    off     = a - BASE;
    exp_err = (a % 4 != 0) || (64'(off) >= 64'(DEPTH) * 64'd4);
    exp_rd  = 32'h0;
    if (!exp_err) begin
      if (we) begin
        for (int b = 0; b < 4; b++) if (be[b]) m[int'(off / 4)][8*b +: 8] = wd[8*b +: 8];
      end else begin
        exp_rd = m[int'(off / 4)];
      end
    end
    if (exp_err) p_er++; else if (we) p_st++; else p_ld++;

    chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
    chk("rsp_rdata", rsp_rdata, exp_rd);
    rd = rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_rdata", rsp_rdata, exp_rd);
      chk("hold_err", {31'b0, rsp_err}, {31'b0, exp_err});
      chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("retire_valid", {31'b0, rsp_valid}, 32'd0);
    chk("retire_req_ready", {31'b0, req_ready}, 32'd1);
  endtask

  logic [31:0] rd;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_be = '0; req_wdata = '0; rsp_ready = 1'b0;
    #2;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Fill the working window so every load has a known model value.
    for (int w = 0; w < 16; w++) xact(1'b1, BASE + 32'(w * 4), 4'hF, $urandom, 0, rd);

    // Store then load.
    xact(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 0, rd);
    xact(1'b0, 32'h10, 4'h0, 32'h0, 0, rd);
    chk("store_load", rd, 32'hDEAD_BEEF);

    // Byte-enable merge.
    xact(1'b1, 32'h20, 4'hF, 32'h1122_3344, 0, rd);
    xact(1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD, 0, rd);
    xact(1'b0, 32'h20, 4'h0, 32'h0, 0, rd);
    chk("be_merge", rd, 32'h11BB_33DD);

    // be=0 no-op store, then error cases.
    xact(1'b1, 32'h20, 4'h0, 32'hFFFF_FFFF, 1, rd);
    xact(1'b0, 32'h22, 4'h0, 32'h0, 0, rd);
    xact(1'b1, BASE + DEPTH * 4, 4'hF, 32'hCAFE_F00D, 0, rd);
    xact(1'b0, BASE, 4'h0, 32'h0, 0, rd);

    // Backpressure.
    xact(1'b0, 32'h10, 4'h0, 32'h0, 5, rd);

    // Reset while a store waits: the store must not land.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_be = 4'hF; req_wdata = 32'h0BAD_F00D;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    p_ld = 0; p_st = 0; p_er = 0;
    xact(1'b0, 32'h10, 4'h0, 32'h0, 0, rd);
    chk("midrst_keep", rd, 32'hDEAD_BEEF);

    // Random mix over the window plus bad addresses.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      int          kind;
      kind = int'($urandom_range(0, 9));
      case (kind)
        0: a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(1, 3));
        1: a = BASE + DEPTH * 4 + 32'($urandom_range(0, 255) * 4);
        2: a = 32'hFFFF_FFFC;
        default: a = BASE + 32'($urandom_range(0, 15) * 4);
      endcase
      xact(1'($urandom), a, 4'($urandom), $urandom, int'($urandom_range(0, 3)), rd);
    end

`ifdef DMEM_PERF_CNT_EN
    chk("perf_loads", perf_loads, 32'(p_ld));
    chk("perf_stores", perf_stores, 32'(p_st));
    chk("perf_errs", perf_errs, 32'(p_er));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
